// File: rtl/uart_pkg.sv
// Shared UART definitions: serialiser state encoding, frame width and baud divisor helper.
package uart_pkg;

    localparam int DATA_BITS = 8;

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} tx_state_t;

    // Clock cycles per bit, truncated toward zero.
    function automatic int baud_div(input int clk_freq, input int baud);
        return clk_freq / baud;
    endfunction

endpackage

// File: rtl/uart_tx_fifo_if.sv
// Byte-write side and line/status side of the UART transmitter.
interface uart_tx_fifo_if #(
    parameter int DEPTH = 16
);
    import uart_pkg::*;

    logic                   wr_en;
    logic [DATA_BITS-1:0]   wr_data;
    logic                   full;
    logic                   empty;
    logic [$clog2(DEPTH):0] count;
    logic                   overflow;
    logic                   busy;
    logic                   tx;

    modport master (
        output wr_en, wr_data,
        input  full, empty, count, overflow, busy, tx
    );

    modport slave (
        input  wr_en, wr_data,
        output full, empty, count, overflow, busy, tx
    );

endinterface

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered full/empty/count; a push into an empty FIFO is not bypassed.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   push,
    input  logic [WIDTH-1:0]       push_data,
    input  logic                   pop,
    output logic [WIDTH-1:0]       pop_data,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count_next;
    logic             push_ok;
    logic             pop_ok;

    // A write while full is dropped even if a pop happens in the same cycle.
    assign push_ok  = push && !full;
    assign pop_ok   = pop && !empty;
    assign pop_data = mem[rd_ptr];

    always_comb begin
        count_next = count;
        if (push_ok && !pop_ok)
            count_next = count + (AW+1)'(1);
        else if (pop_ok && !push_ok)
            count_next = count - (AW+1)'(1);
    end

    // NOTE: storage has no reset; only pointers and flags define validity, so it maps to plain RAM.
    always_ff @(posedge clk) begin
        if (push_ok)
            mem[wr_ptr] <= push_data;
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            full   <= 1'b0;
            empty  <= 1'b1;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + AW'(1);
            if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
            count <= count_next;
            full  <= (count_next == (AW+1)'(DEPTH));
            empty <= (count_next == '0);
        end
    end

endmodule

// File: rtl/uart_tx_fifo.sv
// UART transmitter: FIFO-buffered bytes serialised 8N1, LSB first, with contiguous back-to-back frames.
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int CLK_FREQ = 100_000_000,
    parameter int BAUD     = 115200,
    parameter int DEPTH    = 16
) (
    input  logic           clk,
    input  logic           rst_n,
    uart_tx_fifo_if.slave  bus
);
    localparam int BAUD_DIV = baud_div(CLK_FREQ, BAUD);
    localparam int CNT_W    = $clog2(BAUD_DIV);

    tx_state_t            state, state_n;
    logic [CNT_W-1:0]     baud_cnt, baud_cnt_n;
    logic [2:0]           bit_idx, bit_idx_n;
    logic [DATA_BITS-1:0] shift, shift_n;
    logic [DATA_BITS-1:0] pop_data;
    logic                 pop;
    logic                 bit_end;
    logic                 tx_q, busy_q, overflow_q;

    sync_fifo #(.WIDTH(DATA_BITS), .DEPTH(DEPTH)) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (bus.wr_en),
        .push_data (bus.wr_data),
        .pop       (pop),
        .pop_data  (pop_data),
        .full      (bus.full),
        .empty     (bus.empty),
        .count     (bus.count)
    );

    assign bit_end = (baud_cnt == CNT_W'(BAUD_DIV - 1));

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        state_n    = state;
        baud_cnt_n = baud_cnt + CNT_W'(1);
        bit_idx_n  = bit_idx;
        shift_n    = shift;
        pop        = 1'b0;
        unique case (state)
            IDLE: begin
                baud_cnt_n = '0;
                if (!bus.empty) begin
                    pop       = 1'b1;
                    shift_n   = pop_data;
                    bit_idx_n = '0;
                    state_n   = START;
                end
            end
            START: begin
                if (bit_end) begin
                    baud_cnt_n = '0;
                    state_n    = DATA;
                end
            end
            DATA: begin
                if (bit_end) begin
                    baud_cnt_n = '0;
                    shift_n    = shift >> 1;
                    bit_idx_n  = bit_idx + 3'd1;
                    if (bit_idx == 3'(DATA_BITS - 1))
                        state_n = STOP;
                end
            end
            STOP: begin
                if (bit_end) begin
                    baud_cnt_n = '0;
                    // Chain straight into the next start bit when more data is queued.
                    if (!bus.empty) begin
                        pop       = 1'b1;
                        shift_n   = pop_data;
                        bit_idx_n = '0;
                        state_n   = START;
                    end else begin
                        state_n = IDLE;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            baud_cnt   <= '0;
            bit_idx    <= '0;
            shift      <= '0;
            tx_q       <= 1'b1;
            busy_q     <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            state      <= state_n;
            baud_cnt   <= baud_cnt_n;
            bit_idx    <= bit_idx_n;
            shift      <= shift_n;
            // Line and busy follow the current state one cycle later, keeping tx glitch-free.
            tx_q       <= (state == START) ? 1'b0 : (state == DATA) ? shift[0] : 1'b1;
            busy_q     <= (state != IDLE);
            overflow_q <= bus.wr_en && bus.full;
        end
    end

    assign bus.tx       = tx_q;
    assign bus.busy     = busy_q;
    assign bus.overflow = overflow_q;

endmodule
